// File: rtl/uni_arb_pkg.sv
// Shared types for uni_arbiter: FSM states, grant bit positions and the request buffer layout.
// The ARB_STARVE_GUARD_EN build option lives in uni_arbiter / arb_starve_cnt.
package uni_arb_pkg;

  localparam int CPU_WIDTH   = 64;
  localparam int REQTYP_W    = 2;
  localparam int SIZE_W      = 3;
  localparam int RESP_W      = 2;
  localparam int CNT_W       = 4;
  localparam int GNT_IFU_BIT = 0;
  localparam int GNT_LSU_BIT = 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GNT_IFU = 2'd1,
    GNT_LSU = 2'd2
  } arb_state_e;

  typedef struct packed {
    logic [REQTYP_W-1:0]  reqtyp;
    logic [CPU_WIDTH-1:0] addr;
    logic [CPU_WIDTH-1:0] wdata;
    logic [SIZE_W-1:0]    size;
  } uni_req_t;

  // One-hot owner decode of an FSM state.
  function automatic logic [1:0] gnt_decode(input arb_state_e state);
    logic [1:0] gnt;
    gnt = 2'b00;
    case (state)
      GNT_IFU: gnt[GNT_IFU_BIT] = 1'b1;
      GNT_LSU: gnt[GNT_LSU_BIT] = 1'b1;
      default: gnt = 2'b00;
    endcase
    return gnt;
  endfunction

endpackage

// File: rtl/uni_if.sv
// uni request/response bundle shared by core_top masters, the arbiter and uni2axi.
// slave modport is the side that accepts requests; master modport issues them.
interface uni_if #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
) ();
  import uni_arb_pkg::*;

  logic                valid;
  logic [REQTYP_W-1:0] reqtyp;
  logic [ADDR_W-1:0]   addr;
  logic [DATA_W-1:0]   wdata;
  logic [SIZE_W-1:0]   size;
  logic                ready;
  logic [DATA_W-1:0]   rdata;
  logic [RESP_W-1:0]   resp;

  modport slave  (input valid, reqtyp, addr, wdata, size, output ready, rdata, resp);
  modport master (output valid, reqtyp, addr, wdata, size, input ready, rdata, resp);

endinterface

// File: rtl/arb_starve_cnt.sv
// Saturating count of LSU grants taken while the IFU waits; hit flags the configured limit.
// Only compiled when ARB_STARVE_GUARD_EN is defined.
`ifdef ARB_STARVE_GUARD_EN
module arb_starve_cnt
  import uni_arb_pkg::*;
#(
  parameter int MAX = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc,
  input  logic clr,
  output logic hit
);

  logic [CNT_W-1:0] cnt;

  // Clear wins over increment; count sticks at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= {CNT_W{1'b0}};
    end else if (clr) begin
      cnt <= {CNT_W{1'b0}};
    end else if (inc && (cnt != {CNT_W{1'b1}})) begin
      cnt <= cnt + CNT_W'(1);
    end else begin
      cnt <= cnt;
    end
  end

  assign hit = (cnt == CNT_W'(MAX));

endmodule
`endif

// File: rtl/uni_arbiter.sv
// Registered IFU/LSU arbiter in front of uni2axi: latches the winner and holds it until downstream ready.
// Define ARB_STARVE_GUARD_EN to let the IFU through after STARVE_MAX back-to-back LSU wins.
module uni_arbiter
  import uni_arb_pkg::*;
#(
  parameter int ADDR_W     = CPU_WIDTH,
  parameter int DATA_W     = CPU_WIDTH,
  parameter int STARVE_MAX = 4
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  uni_if.slave       UniIf_ifu_S,
  uni_if.slave       UniIf_lsu_S,
  uni_if.master      UniIf_M,
  output logic [1:0] o_gnt
);

  arb_state_e state;
  uni_req_t   req_buf;
  uni_req_t   ifu_req;
  uni_req_t   lsu_req;
  logic       m_valid;
  logic [1:0] gnt;
  logic       pick_lsu;
  logic       pick_ifu;
  logic       starve_hit;

  // Live request fields widened into the buffer layout.
  always_comb begin
    ifu_req        = '0;
    ifu_req.reqtyp = UniIf_ifu_S.reqtyp;
    ifu_req.addr   = CPU_WIDTH'(UniIf_ifu_S.addr);
    ifu_req.wdata  = CPU_WIDTH'(UniIf_ifu_S.wdata);
    ifu_req.size   = UniIf_ifu_S.size;
    lsu_req        = '0;
    lsu_req.reqtyp = UniIf_lsu_S.reqtyp;
    lsu_req.addr   = CPU_WIDTH'(UniIf_lsu_S.addr);
    lsu_req.wdata  = CPU_WIDTH'(UniIf_lsu_S.wdata);
    lsu_req.size   = UniIf_lsu_S.size;
  end

  // Winner selection, only meaningful while idle.
  always_comb begin
    pick_lsu = 1'b0;
    pick_ifu = 1'b0;
    if (state == IDLE) begin
      if (UniIf_lsu_S.valid && !(starve_hit && UniIf_ifu_S.valid)) begin
        pick_lsu = 1'b1;
      end else if (UniIf_ifu_S.valid) begin
        pick_ifu = 1'b1;
      end else begin
        pick_lsu = 1'b0;
        pick_ifu = 1'b0;
      end
    end else begin
      pick_lsu = 1'b0;
      pick_ifu = 1'b0;
    end
  end

`ifdef ARB_STARVE_GUARD_EN
  logic starve_inc;
  logic starve_clr;

  assign starve_inc = pick_lsu && UniIf_ifu_S.valid;
  assign starve_clr = pick_ifu || ((state == IDLE) && !UniIf_ifu_S.valid);

  arb_starve_cnt #(
    .MAX (STARVE_MAX)
  ) u_starve_cnt (
    .clk   (i_clk),
    .rst_n (i_rst_n),
    .inc   (starve_inc),
    .clr   (starve_clr),
    .hit   (starve_hit)
  );
`else
  // Strict LSU priority: STARVE_MAX has no effect in this build.
  assign starve_hit = (STARVE_MAX < 1) && 1'b0;
`endif

  // Grant FSM with request buffer; valid and owner are registered copies of the next state.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state   <= IDLE;
      req_buf <= '0;
      m_valid <= 1'b0;
      gnt     <= 2'b00;
    end else begin
      case (state)
        IDLE: begin
          if (pick_lsu) begin
            state   <= GNT_LSU;
            req_buf <= lsu_req;
            m_valid <= 1'b1;
            gnt     <= gnt_decode(GNT_LSU);
          end else if (pick_ifu) begin
            state   <= GNT_IFU;
            req_buf <= ifu_req;
            m_valid <= 1'b1;
            gnt     <= gnt_decode(GNT_IFU);
          end else begin
            state   <= IDLE;
            m_valid <= 1'b0;
            gnt     <= gnt_decode(IDLE);
          end
        end
        GNT_IFU, GNT_LSU: begin
          if (UniIf_M.ready) begin
            state   <= IDLE;
            m_valid <= 1'b0;
            gnt     <= gnt_decode(IDLE);
          end else begin
            state   <= state;
            m_valid <= 1'b1;
            gnt     <= gnt_decode(state);
          end
        end
        default: begin
          state   <= IDLE;
          m_valid <= 1'b0;
          gnt     <= 2'b00;
        end
      endcase
    end
  end

  assign UniIf_M.valid  = m_valid;
  assign UniIf_M.reqtyp = req_buf.reqtyp;
  assign UniIf_M.addr   = req_buf.addr[ADDR_W-1:0];
  assign UniIf_M.wdata  = req_buf.wdata[DATA_W-1:0];
  assign UniIf_M.size   = req_buf.size;
  assign o_gnt          = gnt;

  // Response steering; a withdrawn owner still receives its completion pulse.
  always_comb begin
    UniIf_ifu_S.ready = 1'b0;
    UniIf_ifu_S.rdata = {DATA_W{1'b0}};
    UniIf_ifu_S.resp  = {RESP_W{1'b0}};
    UniIf_lsu_S.ready = 1'b0;
    UniIf_lsu_S.rdata = {DATA_W{1'b0}};
    UniIf_lsu_S.resp  = {RESP_W{1'b0}};
    if (gnt[GNT_IFU_BIT]) begin
      UniIf_ifu_S.ready = UniIf_M.ready;
      UniIf_ifu_S.rdata = UniIf_M.rdata;
      UniIf_ifu_S.resp  = UniIf_M.resp;
    end else if (gnt[GNT_LSU_BIT]) begin
      UniIf_lsu_S.ready = UniIf_M.ready;
      UniIf_lsu_S.rdata = UniIf_M.rdata;
      UniIf_lsu_S.resp  = UniIf_M.resp;
    end else begin
      UniIf_ifu_S.ready = 1'b0;
      UniIf_lsu_S.ready = 1'b0;
    end
  end

endmodule

// File: tb/tb_uni_arbiter.sv
// Scoreboard bench for uni_arbiter: transaction-level owner model feeds an expected queue,
// a negedge monitor compares grant, routing and buffered fields against it.
module tb_uni_arbiter;
  import uni_arb_pkg::*;

  localparam int STARVE_MAX = 4;
  localparam int N_STARVE   = 50;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] gnt;

  uni_if #(.ADDR_W(64), .DATA_W(64)) ifu_if ();
  uni_if #(.ADDR_W(64), .DATA_W(64)) lsu_if ();
  uni_if #(.ADDR_W(64), .DATA_W(64)) m_if ();

  uni_arbiter #(
    .ADDR_W     (64),
    .DATA_W     (64),
    .STARVE_MAX (STARVE_MAX)
  ) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .UniIf_ifu_S (ifu_if),
    .UniIf_lsu_S (lsu_if),
    .UniIf_M     (m_if),
    .o_gnt       (gnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          owner;
    logic [1:0]  reqtyp;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [2:0]  size;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail = 0;
  int   owner = -1;  // -1 none, 0 IFU, 1 LSU
  int   starve = 0;
  int   p_req = 0, p_wd = 0, p_ready = 0;
  int   dut_ifu_cnt = 0, dut_lsu_cnt = 0;

  bit          m_pend[2];
  bit          m_valid[2];
  logic [1:0]  m_reqtyp[2];
  logic [63:0] m_addr[2];
  logic [63:0] m_wdata[2];
  logic [2:0]  m_size[2];
  bit          ds_ready;
  logic [63:0] ds_rdata;
  logic [1:0]  ds_resp;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive();
    ifu_if.valid  = m_valid[0];
    ifu_if.reqtyp = m_reqtyp[0];
    ifu_if.addr   = m_addr[0];
    ifu_if.wdata  = m_wdata[0];
    ifu_if.size   = m_size[0];
    lsu_if.valid  = m_valid[1];
    lsu_if.reqtyp = m_reqtyp[1];
    lsu_if.addr   = m_addr[1];
    lsu_if.wdata  = m_wdata[1];
    lsu_if.size   = m_size[1];
    m_if.ready    = ds_ready;
    m_if.rdata    = ds_rdata;
    m_if.resp     = ds_resp;
  endtask

  task automatic set_req(input int i, input logic [1:0] typ, input logic [63:0] addr,
                         input logic [63:0] wdata, input logic [2:0] size);
    m_pend[i]   = 1'b1;
    m_valid[i]  = 1'b1;
    m_reqtyp[i] = typ;
    m_addr[i]   = addr;
    m_wdata[i]  = wdata;
    m_size[i]   = size;
  endtask

  task automatic grant(input int i);
    exp_t e;
    e.owner  = i;
    e.reqtyp = m_reqtyp[i];
    e.addr   = m_addr[i];
    e.wdata  = m_wdata[i];
    e.size   = m_size[i];
    exp_q.push_back(e);
    owner = i;
  endtask

  // Reference: one transaction owns the port until downstream ready, LSU preferred.
  task automatic model_edge();
    bit force_ifu;
    force_ifu = 1'b0;
    if (owner < 0) begin
`ifdef ARB_STARVE_GUARD_EN
      force_ifu = m_valid[0] && (starve == STARVE_MAX);
`endif
      if (m_valid[1] && !force_ifu) begin
        grant(1);
        if (m_valid[0]) starve = (starve < 15) ? starve + 1 : 15;
      end else if (m_valid[0]) begin
        grant(0);
        starve = 0;
      end
      if (!m_valid[0]) starve = 0;
    end else if (ds_ready) begin
      m_pend[owner] = 1'b0;
      owner = -1;
    end
  endtask

  task automatic step_inputs();
    for (int i = 0; i < 2; i++) begin
      if (!m_pend[i]) begin
        if ($urandom_range(99) < p_req)
          set_req(i, 2'($urandom_range(3)), {$urandom, $urandom}, {$urandom, $urandom},
                  3'($urandom_range(7)));
        else
          m_valid[i] = 1'b0;
      end else if (owner == i && m_valid[i] && $urandom_range(99) < p_wd) begin
        m_valid[i] = 1'b0;
        m_addr[i]  = 64'hDEAD;
      end
    end
    ds_ready = (owner >= 0) && ($urandom_range(99) < p_ready);
    ds_rdata = {$urandom, $urandom};
    ds_resp  = 2'($urandom_range(3));
    drive();
  endtask

  task automatic run_cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      model_edge();
      #1;
      step_inputs();
    end
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    owner = -1;
    starve = 0;
    exp_q.delete();
    for (int i = 0; i < 2; i++) begin
      m_pend[i] = 1'b0;
      m_valid[i] = 1'b0;
    end
    ds_ready = 1'b1;
    ds_rdata = 64'h13;
    drive();
    repeat (2) @(posedge clk);
    #1;
    check("rst_gnt", gnt, 2'b00);
    check("rst_m_valid", m_if.valid, 1'b0);
    check("rst_m_addr", m_if.addr, 64'd0);
    check("rst_m_wdata", m_if.wdata, 64'd0);
    check("rst_ifu_ready", ifu_if.ready, 1'b0);
    check("rst_lsu_rdata", lsu_if.rdata, 64'd0);
    ds_ready = 1'b0;
    drive();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Monitor: per-cycle owner/routing check, field check against queue head, pop on handshake.
  always @(negedge clk) begin : monitor
    logic [1:0] eg;
    if (rst_n) begin
      eg = (owner == 0) ? 2'b01 : (owner == 1) ? 2'b10 : 2'b00;
      check("o_gnt", gnt, eg);
      check("m_valid", m_if.valid, owner >= 0);
      check("ifu_ready", ifu_if.ready, (owner == 0) ? ds_ready : 1'b0);
      check("ifu_rdata", ifu_if.rdata, (owner == 0) ? ds_rdata : 64'd0);
      check("ifu_resp", ifu_if.resp, (owner == 0) ? ds_resp : 2'd0);
      check("lsu_ready", lsu_if.ready, (owner == 1) ? ds_ready : 1'b0);
      check("lsu_rdata", lsu_if.rdata, (owner == 1) ? ds_rdata : 64'd0);
      check("lsu_resp", lsu_if.resp, (owner == 1) ? ds_resp : 2'd0);
      if (m_if.valid) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL m_unexpected: got valid=1 expected no pending grant (t=%0t)", $time);
        end else begin
          check("m_addr", m_if.addr, exp_q[0].addr);
          check("m_wdata", m_if.wdata, exp_q[0].wdata);
          check("m_reqtyp", m_if.reqtyp, exp_q[0].reqtyp);
          check("m_size", m_if.size, exp_q[0].size);
          if (m_if.ready) begin
            if (gnt == 2'b01) dut_ifu_cnt++;
            else if (gnt == 2'b10) dut_lsu_cnt++;
            exp_q.delete(0);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int base_i, base_l, total, exp_ifu;
    apply_reset();

    // Reset while LSU transaction is in flight: valid must drop without a clock.
    set_req(1, 2'd1, 64'h8000_0100, 64'h55, 3'd3);
    drive();
    run_cycles(2);
    ds_ready = 1'b1;
    drive();
    #2 rst_n = 1'b0;
    #1;
    check("midrst_m_valid", m_if.valid, 1'b0);
    check("midrst_gnt", gnt, 2'b00);
    check("midrst_lsu_ready", lsu_if.ready, 1'b0);
    check("midrst_ifu_ready", ifu_if.ready, 1'b0);
    check("midrst_m_addr", m_if.addr, 64'd0);
    apply_reset();

    // Lone IFU read, downstream ready in cycle 3 with rdata 0x13.
    set_req(0, 2'd0, 64'h8000_0000, 64'd0, 3'd2);
    drive();
    run_cycles(3);
    ds_ready = 1'b1;
    ds_rdata = 64'h13;
    drive();
    @(negedge clk);
    #1;
    check("ifu_read_rdata", ifu_if.rdata, 64'h13);
    check("ifu_read_lsu_ready", lsu_if.ready, 1'b0);
    run_cycles(3);

    // Simultaneous valids; granted masters withdraw and scribble addr.
    set_req(1, 2'd1, 64'h8000_1000, 64'hCAFE, 3'd3);
    set_req(0, 2'd0, 64'h8000_0040, 64'd0, 3'd2);
    drive();
    p_wd = 100;
    p_ready = 30;
    run_cycles(40);

    // Random traffic.
    apply_reset();
    p_req = 40;
    p_wd = 10;
    p_ready = 50;
    run_cycles(3000);

    // Both masters saturated, ready on the first valid cycle.
    apply_reset();
    p_req = 100;
    p_wd = 0;
    p_ready = 100;
    base_i = dut_ifu_cnt;
    base_l = dut_lsu_cnt;
    total = 0;
    for (int c = 0; c < 400 && total < N_STARVE; c++) begin
      run_cycles(1);
      @(negedge clk);
      #1;
      total = (dut_ifu_cnt - base_i) + (dut_lsu_cnt - base_l);
    end
`ifdef ARB_STARVE_GUARD_EN
    exp_ifu = N_STARVE / (STARVE_MAX + 1);
`else
    exp_ifu = 0;
`endif
    check("starve_txn_count", total, N_STARVE);
    check("starve_ifu_grants", dut_ifu_cnt - base_i, exp_ifu);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uni_arbiter.md
# uni_arbiter

Registered two-requester arbiter that shares the single downstream uni interface (feeding uni2axi) between the IFU and LSU uni masters of core_top. It replaces combinational valid-priority muxing with a grant FSM that latches the winning request and holds it stable until the downstream completion handshake. LSU has priority, with an optional starvation guard for the IFU. Instantiated in the top level between core_top and uni2axi.

## Interface
- ADDR_W, 64 (`CPU_WIDTH`): uni address width.
- DATA_W, 64 (`CPU_WIDTH`): uni data width.
- STARVE_MAX, 4: consecutive LSU grants allowed while the IFU is pending (used only with the guard compiled in); legal range 1..15.
- i_clk  input  1  clock; all state updates on the rising edge.
- i_rst_n  input  1  reset; asynchronous, active-low.
- UniIf_ifu_S  uni_if slave  ADDR_W/DATA_W  IFU requester: valid, reqtyp, addr, wdata, size in; ready, rdata, resp out.
- UniIf_lsu_S  uni_if slave  ADDR_W/DATA_W  LSU requester, same signals.
- UniIf_M  uni_if master  ADDR_W/DATA_W  downstream port to uni2axi.
- o_gnt  output  2  one-hot current owner: [0] IFU, [1] LSU; 2'b00 when idle.

## Operation
- FSM states: IDLE, GNT_IFU, GNT_LSU.
- IDLE:
  - If LSU valid, go to GNT_LSU.
  - Else if IFU valid, go to GNT_IFU.
  - Else stay in IDLE.
  - On the transition edge, latch the winner's reqtyp, addr, wdata and size into the request buffer.
- GNT_x:
  - UniIf_M.valid = 1; request fields are driven from the buffer, not live inputs.
  - Buffered fields are held constant until UniIf_M.ready = 1.
  - On UniIf_M.ready, go to IDLE.
- Response routing (combinational):
  - Granted master: ready = UniIf_M.ready; rdata/resp = UniIf_M.rdata/resp.
  - Non-granted master: ready = 0, rdata = 0, resp = 0.
  - In IDLE both masters see 0 on all three.
- Withdrawn request: if the granted master drops valid before completion, the buffered transaction still completes downstream. The ready pulse is still routed to that master and the response is discarded by it. No abort is issued.
- Simultaneous valids in IDLE: LSU wins (subject to the guard).
- Reset mid-transaction:
  - State returns to IDLE immediately and UniIf_M.valid drops asynchronously.
  - uni2axi shares the same reset, so no orphan beat survives.

## Timing
- Reset values: UniIf_M.valid = 0; UniIf_M addr/wdata/reqtyp/size = 0; both slave ready = 0, rdata = 0, resp = 0; o_gnt = 2'b00; starvation counter = 0.
- Arbitration latency:
  - A request first seen in IDLE at cycle n drives UniIf_M.valid at cycle n+1.
  - Downstream ready at cycle k reaches the master in the same cycle k (zero added latency).
  - State is IDLE at k+1; the earliest next grant drives UniIf_M.valid at k+2.
  - Minimum transaction spacing is one idle bubble.
- o_gnt is registered and is a direct decode of the state.
- Masters hold valid and fields until ready (codebase rule). The arbiter tolerates violations only as described under Operation.

## Configuration
- ARB_STARVE_GUARD_EN defined:
  - A counter increments on each IDLE→GNT_LSU transition taken while IFU valid is also high.
  - When the count equals STARVE_MAX and IFU valid is high in IDLE, the FSM goes to GNT_IFU even if LSU is valid.
  - The counter clears on any IFU grant, or on an IDLE cycle with IFU not valid.
- ARB_STARVE_GUARD_EN undefined: strict LSU priority; counter logic absent; STARVE_MAX ignored.

## Structure
- Package uni_arb_pkg:
  - arb_state_e enum (IDLE = 2'd0, GNT_IFU = 2'd1, GNT_LSU = 2'd2).
  - GNT_IFU_BIT = 0 and GNT_LSU_BIT = 1 constants.
  - Request-buffer struct uni_req_t {reqtyp, addr, wdata, size}.
- Sub-module arb_starve_cnt: saturating counter with inc/clr inputs and a hit output. Compiled only under ARB_STARVE_GUARD_EN.
- Request buffer and FSM are inline in uni_arbiter.

## Test plan
- Reset mid-transaction: raise LSU valid, addr=0x8000_0100; assert i_rst_n=0 at grant cycle+1 → UniIf_M.valid=0 in the same cycle, o_gnt=00, all slave ready=0.
- Lone IFU read: IFU valid at cycle 0, addr=0x8000_0000; downstream ready at cycle 3 with rdata=0x13 → UniIf_M.valid cycles 1–3; IFU sees ready=1, rdata=0x13 at cycle 3; o_gnt=01 during cycles 1–3; LSU sees ready=0.
- Simultaneous valids at cycle 0: LSU store addr=0x8000_1000 and IFU fetch → LSU served first with o_gnt=10. IFU is granted two cycles after the LSU ready (one bubble), with unchanged addr.
- Field stability: during GNT_LSU the LSU changes addr to 0xDEAD and drops valid → UniIf_M.addr stays 0x8000_1000 and valid stays 1 until ready; the ready pulse is still routed to the LSU.
- Starvation with guard, STARVE_MAX=4: LSU and IFU both permanently valid, downstream ready one cycle after each grant → grant order LSU,LSU,LSU,LSU,IFU, repeating. Without the guard: LSU only, IFU never granted over 50 transactions.
